// File: rtl/log_dump_ctrl.sv
// Reader side of the sample log: waits for the logger to report full, reads every word in order
// and streams it out over valid/ready. Optional trailing checksum word under LOG_DUMP_CSUM_EN.
module log_dump_ctrl #(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned BRAM_DATA_WIDTH = 16,
  parameter int unsigned RD_LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_mem_full,
  output logic                       o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
  input  logic [31:0]                i_data_log,
  output logic [BRAM_DATA_WIDTH-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitFull = 3'd1;
  localparam logic [2:0] StFetch    = 3'd2;
  localparam logic [2:0] StLat      = 3'd3;
  localparam logic [2:0] StSend     = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;
  localparam logic [2:0] StCsum     = 3'd6;

  localparam logic [BRAM_ADDR_WIDTH-1:0] LastAddr = {BRAM_ADDR_WIDTH{1'b1}};

  logic [2:0]                 state_q, state_d;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                 lat_q, lat_d;
  logic [BRAM_DATA_WIDTH-1:0] data_q, data_d;
  logic                       err_q, err_d;
  logic                       reading;
`ifdef LOG_DUMP_CSUM_EN
  logic [BRAM_DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  // Only the low sample bits of the logger bus carry data.
  logic unused_data_hi;
  assign unused_data_hi = ^i_data_log[31:BRAM_DATA_WIDTH];

  // States in which the logger must stay valid (full) for the dump to be trustworthy.
  always_comb begin
    reading = (state_q == StFetch) || (state_q == StLat) || (state_q == StSend);
`ifdef LOG_DUMP_CSUM_EN
    reading = reading || (state_q == StCsum);
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef LOG_DUMP_CSUM_EN
    sum_d   = sum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StWaitFull;
          err_d   = 1'b0;
          addr_d  = '0;
`ifdef LOG_DUMP_CSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StWaitFull: begin
        if (i_mem_full) begin
          state_d = StFetch;
          addr_d  = '0;
        end
      end
      StFetch: begin
        lat_d   = 3'(RD_LATENCY);
        state_d = StLat;
      end
      StLat: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          data_d  = i_data_log[BRAM_DATA_WIDTH-1:0];
          state_d = StSend;
        end
      end
      StSend: begin
        if (i_ready) begin
`ifdef LOG_DUMP_CSUM_EN
          sum_d = sum_q + data_q;
`endif
          if (addr_q == LastAddr) begin
`ifdef LOG_DUMP_CSUM_EN
            data_d  = sum_d;
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
`ifdef LOG_DUMP_CSUM_EN
      StCsum: begin
        if (i_ready) state_d = StDone;
      end
`endif
      StDone: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: state_d = StIdle;
    endcase

    // Writer re-armed under us: the rest of the log is no longer the captured one.
    if (reading && !i_mem_full) begin
      state_d = StIdle;
      addr_d  = '0;
      err_d   = 1'b1;
    end

    if ((state_q != StIdle) && i_abort) begin
      state_d = StIdle;
      addr_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef LOG_DUMP_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef LOG_DUMP_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    o_read_log = (state_q == StFetch) || (state_q == StLat) || (state_q == StSend);
    o_valid    = (state_q == StSend);
`ifdef LOG_DUMP_CSUM_EN
    o_valid    = o_valid || (state_q == StCsum);
`endif
    o_busy     = (state_q != StIdle);
    o_done     = (state_q == StDone);
    o_addr_log = addr_q;
    o_data     = data_q;
    o_error    = err_q;
  end

endmodule
